// File: rtl/bcd_display_pkg.sv
// bcd_display_pkg: segment encodings, scan states and leading-zero blanking helper
package bcd_display_pkg;

  typedef enum logic [1:0] {ST_OFF, ST_BLANK, ST_SHOW} scan_state_e;

  localparam logic [0:6] SEG_OFF  = 7'b1111111;
  localparam logic [0:6] SEG_DASH = 7'b1111110;

  localparam logic [0:6] SEG_HEX [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  // A digit is blanked when it is not the rightmost one and it and every higher digit are zero.
  function automatic logic lz_blanked(input logic [31:0] digits, input int i);
    logic b;
    b = (i != 0);
    for (int j = 0; j < 8; j++)
      if (j >= i && digits[4*j +: 4] != 4'h0) b = 1'b0;
    return b;
  endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// seg7_hex_decode: nibble to active-low a..g segments, dash for 10-15 in BCD mode
module seg7_hex_decode
  import bcd_display_pkg::*;
(
  input  logic [3:0] nibble_i,
  input  logic       hex_mode_i,
  output logic [0:6] seg_n_o
);

  assign seg_n_o = (!hex_mode_i && nibble_i > 4'd9) ? SEG_DASH : SEG_HEX[nibble_i];

endmodule

// File: rtl/bcd_display_scanner.sv
// bcd_display_scanner: time-multiplexed multi-digit 7-segment driver with dead-time and blanking
module bcd_display_scanner
  import bcd_display_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    load,
  input  logic                    enable,
  input  logic                    hex_mode,
  input  logic                    lz_blank,
  output logic [0:6]              seg_n,
  output logic                    dp_n,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic                    frame_tick
);

  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  localparam int CW = $clog2(SCAN_DIV);

  logic [CW-1:0]           cnt_q, cnt_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] snap_q;
  logic [NUM_DIGITS-1:0]   dps_q, an_q;
  logic [0:6]              pat_q, seg_q, dec;
  logic                    pdp_q, dp_q, ft_q;
  logic [3:0]              nib;
  logic                    last, idx_last, blank;
  scan_state_e             st;

  seg7_hex_decode u_dec (
    .nibble_i  (nib),
    .hex_mode_i(hex_mode),
    .seg_n_o   (dec)
  );

  // Scan state, slot/digit advance and the pattern of the digit about to be shown
  always_comb begin
    st       = !enable ? ST_OFF : (cnt_q < CW'(BLANK_CYCLES)) ? ST_BLANK : ST_SHOW;
    last     = cnt_q == CW'(SCAN_DIV - 1);
    idx_last = idx_q == IW'(NUM_DIGITS - 1);
    cnt_d    = last ? '0 : cnt_q + 1'b1;
    idx_d    = last ? (idx_last ? '0 : idx_q + 1'b1) : idx_q;
    nib      = snap_q[{idx_q, 2'b00} +: 4];
    blank    = lz_blank && lz_blanked(32'(snap_q), int'(idx_q));
  end

  // Snapshot capture, scan counters and registered display outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      snap_q <= '0;
      dps_q  <= '0;
      cnt_q  <= '0;
      idx_q  <= '0;
      pat_q  <= SEG_OFF;
      pdp_q  <= 1'b1;
      seg_q  <= SEG_OFF;
      dp_q   <= 1'b1;
      an_q   <= '1;
      ft_q   <= 1'b0;
    end else begin
      if (load) begin
        snap_q <= data_in;
        dps_q  <= dp_in;
      end
      if (st == ST_OFF) begin
        cnt_q <= '0;
        idx_q <= '0;
        seg_q <= SEG_OFF;
        dp_q  <= 1'b1;
        an_q  <= '1;
        ft_q  <= 1'b0;
      end else begin
        cnt_q <= cnt_d;
        idx_q <= idx_d;
        ft_q  <= last && idx_last;
        if (cnt_q == '0) begin
          pat_q <= blank ? SEG_OFF : dec;
          pdp_q <= ~dps_q[idx_q];
        end
        an_q  <= (st == ST_SHOW) ? ~(NUM_DIGITS'(1) << idx_q) : '1;
        seg_q <= (st == ST_SHOW) ? pat_q : SEG_OFF;
        dp_q  <= (st == ST_SHOW) ? pdp_q : 1'b1;
      end
    end
  end

  assign seg_n      = seg_q;
  assign dp_n       = dp_q;
  assign an_n       = an_q;
  assign frame_tick = ft_q;

endmodule

// File: tb/tb_bcd_display_scanner.sv
// tb_bcd_display_scanner: directed scoreboard bench for the display scanner
module tb_bcd_display_scanner;

  logic        clk = 1'b0;
  logic        rst, load, enable, hex_mode, lz_blank;
  logic [15:0] data_in;
  logic [3:0]  dp_in;
  logic [0:6]  seg_n;
  logic        dp_n, frame_tick;
  logic [3:0]  an_n;

  typedef struct {
    logic [3:0] an;
    logic [0:6] seg;
    logic       dp;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_pass = 0;

  logic [0:6] tbl [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };
  localparam logic [0:6] OFF  = 7'b1111111;
  localparam logic [0:6] DASH = 7'b1111110;

  bcd_display_scanner #(.NUM_DIGITS(4), .SCAN_DIV(8), .BLANK_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .dp_in(dp_in), .load(load),
    .enable(enable), .hex_mode(hex_mode), .lz_blank(lz_blank),
    .seg_n(seg_n), .dp_n(dp_n), .an_n(an_n), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic push(input logic [3:0] an, input logic [0:6] seg, input logic dp);
    exp_t e;
    e.an = an;
    e.seg = seg;
    e.dp = dp;
    exp_q.push_back(e);
  endtask

  task automatic load_val(input logic [15:0] d, input logic [3:0] dp);
    @(negedge clk);
    data_in = d;
    dp_in = dp;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic restart();
    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    enable = 1'b1;
  endtask

  task automatic drain(input string tag);
    int budget = 400;
    int slot = 0;
    logic [3:0] prev = 4'hF;
    exp_t e;
    while (exp_q.size() > 0 && budget > 0) begin
      @(negedge clk);
      budget--;
      if (an_n !== 4'hF && prev === 4'hF) begin
        e = exp_q.pop_front();
        chk($sformatf("%s_an%0d", tag, slot), 32'(an_n), 32'(e.an));
        chk($sformatf("%s_seg%0d", tag, slot), 32'(seg_n), 32'(e.seg));
        chk($sformatf("%s_dp%0d", tag, slot), 32'(dp_n), 32'(e.dp));
        slot++;
      end
      prev = an_n;
    end
    chk($sformatf("%s_timeout", tag), 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic wait_an(input logic [3:0] target, input string tag);
    int budget = 100;
    while (an_n !== target && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    chk(tag, 32'(an_n), 32'(target));
  endtask

  initial begin
    logic [3:0] ea;
    int d;
    int budget;
    rst = 1'b1; enable = 1'b0; load = 1'b0; data_in = '0; dp_in = '0;
    hex_mode = 1'b1; lz_blank = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_an", 32'(an_n), 32'hF);
    chk("rst_seg", 32'(seg_n), 32'(OFF));
    chk("rst_dp", 32'(dp_n), 32'd1);
    chk("rst_ft", 32'(frame_tick), 32'd0);
    rst = 1'b0;

    for (int v = 0; v < 16; v++) begin
      load_val(16'(v), 4'b0000);
      restart();
      push(4'b1110, tbl[v], 1'b1);
      drain($sformatf("sweep%0d", v));
    end

    hex_mode = 1'b0;
    load_val(16'hC3A9, 4'b0000);
    restart();
    push(4'b1110, 7'b0000100, 1'b1);
    push(4'b1101, DASH, 1'b1);
    push(4'b1011, 7'b0000110, 1'b1);
    push(4'b0111, DASH, 1'b1);
    drain("bcd");
    hex_mode = 1'b1;

    load_val(16'h1234, 4'b0000);
    restart();
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      d = (k / 8) % 4;
      ea = (k % 8 < 2) ? 4'hF : ~(4'b0001 << d);
      chk($sformatf("scan_an%0d", k), 32'(an_n), 32'(ea));
      chk($sformatf("scan_ft%0d", k), 32'(frame_tick), 32'(k % 32 == 31));
      chk($sformatf("scan_1hot%0d", k), 32'($countones(~an_n) <= 1), 32'd1);
      if (k % 8 >= 2) chk($sformatf("scan_seg%0d", k), 32'(seg_n), 32'(tbl[4 - d]));
    end

    lz_blank = 1'b1;
    load_val(16'h0050, 4'b1000);
    restart();
    push(4'b1110, tbl[0], 1'b1);
    push(4'b1101, tbl[5], 1'b1);
    push(4'b1011, OFF, 1'b1);
    push(4'b0111, OFF, 1'b0);
    drain("lz50");
    load_val(16'h0000, 4'b0000);
    restart();
    push(4'b1110, tbl[0], 1'b1);
    push(4'b1101, OFF, 1'b1);
    push(4'b1011, OFF, 1'b1);
    push(4'b0111, OFF, 1'b1);
    drain("lz00");
    lz_blank = 1'b0;

    load_val(16'h8888, 4'b0000);
    restart();
    @(negedge clk);
    wait_an(4'b1101, "mid_find");
    data_in = 16'h1111;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    budget = 10;
    while (an_n === 4'b1101 && budget > 0) begin
      chk("mid_keep", 32'(seg_n), 32'(tbl[8]));
      @(negedge clk);
      budget--;
    end
    push(4'b1011, tbl[1], 1'b1);
    drain("mid_next");

    wait_an(4'b1011, "rst_find");
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_an", 32'(an_n), 32'hF);
    chk("rst_mid_seg", 32'(seg_n), 32'(OFF));
    rst = 1'b0;
    @(negedge clk);
    chk("rst_rel_an0", 32'(an_n), 32'hF);
    @(negedge clk);
    chk("rst_rel_an1", 32'(an_n), 32'hF);
    @(negedge clk);
    chk("rst_rel_an2", 32'(an_n), 32'hE);
    chk("rst_rel_seg", 32'(seg_n), 32'(tbl[0]));

    enable = 1'b0;
    @(negedge clk);
    chk("en_off_an", 32'(an_n), 32'hF);
    chk("en_off_seg", 32'(seg_n), 32'(OFF));
    chk("en_off_dp", 32'(dp_n), 32'd1);
    repeat (3) @(negedge clk);
    enable = 1'b1;
    push(4'b1110, tbl[0], 1'b1);
    drain("reen");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
